// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a show-ahead-less FIFO (data one cycle after
// read enable) into a 2-entry output buffer with a valid/ready interface.
// Optional burst framing is enabled by defining FIFO_RD_BURST_EN: reads are
// then issued in bursts of BURST words once the FIFO is not almost-empty,
// and the final word of each burst is flagged on o_last.
module fifo_reader #(
  parameter int WORD_WIDTH = 8,
  parameter int BURST      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_empty,
  input  logic                  i_aempty,
  output logic                  o_r_en,
  input  logic [WORD_WIDTH-1:0] i_r_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_last
);

  // Output buffer: entry 0 is always the head, entry 1 the second word.
  logic [WORD_WIDTH-1:0] data_q [2];
  logic [WORD_WIDTH-1:0] data_d [2];
  logic [1:0]            last_q, last_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  read_allowed;
  logic                  issue_last;
  logic                  issue;
  logic                  pop;
  logic [1:0]            occ;
  logic                  tail_sel;

  assign o_valid = !reset && (cnt_q != 2'd0);
  assign o_data  = reset ? '0 : data_q[0];
  assign o_last  = !reset && last_q[0];
  assign pop     = o_valid && i_ready;

  // Occupancy if a read were issued now: held + in flight - leaving this cycle.
  assign occ    = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue  = read_allowed && !i_empty && !reset && (occ < 2'd2);
  assign o_r_en = issue;

  // Returning word lands in the slot right behind whatever remains after a pop.
  assign tail_sel = (cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop);

  // Buffer next-state: shift on pop, then append the returning word.
  always_comb begin
    data_d          = data_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    inflight_d      = issue;
    inflight_last_d = issue_last;
    if (pop) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (inflight_q) begin
      data_d[tail_sel] = i_r_data;
      last_d[tail_sel] = inflight_last_q;
      cnt_d            = cnt_d + 2'd1;
    end
  end

  // Buffer and in-flight registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q          <= '{default: '0};
      last_q          <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      data_q          <= data_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

`ifdef FIFO_RD_BURST_EN
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;

  assign read_allowed = (state_q == ST_BURST);
  assign issue_last   = issue && (bcnt_q == CNT_W'(BURST - 1));

  // Burst FSM: start when FIFO is above its level, end after BURST reads.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_aempty) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (issue_last) begin
          bcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (issue) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst state and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end
`else
  logic unused_aempty;

  assign read_allowed = 1'b1;
  assign issue_last   = 1'b0;
  assign unused_aempty = i_aempty;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO model feeds the DUT, and a
// scoreboard of written words checks order, data and burst framing.
module tb_fifo_reader;

  localparam int W     = 8;
  localparam int BURST = 4;
`ifdef FIFO_RD_BURST_EN
  localparam bit BURST_MODE = 1'b1;
`else
  localparam bit BURST_MODE = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         i_empty;
  logic         i_aempty;
  logic         o_r_en;
  logic [W-1:0] i_r_data;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_last;

  fifo_reader #(.WORD_WIDTH(W), .BURST(BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_empty  (i_empty),
    .i_aempty (i_aempty),
    .o_r_en   (o_r_en),
    .i_r_data (i_r_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_last   (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] fifo_q [$];
  logic [W-1:0] exp_q  [$];
  int           level;
  int           n_checks;
  int           n_errors;
  int           cyc;
  int           reads, delivered;
  int           ren_cnt, vld_cnt, first_ren, first_vld, last_vld;
  logic         s_ren, s_vld, s_last;
  logic [W-1:0] s_data;
  logic         prev_stall;
  logic [W-1:0] prev_data;
  logic         prev_last;

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_stats();
    ren_cnt = 0; vld_cnt = 0; first_ren = -1; first_vld = -1; last_vld = -1;
  endtask

  // One clock: present FIFO flags, sample and score outputs, model FIFO read.
  task automatic cycle();
    logic         ren;
    logic [W-1:0] exp_w;
    logic         exp_l;
    i_empty  = (fifo_q.size() == 0);
    i_aempty = (fifo_q.size() <= level);
    #1;
    ren = o_r_en;
    s_ren = o_r_en; s_vld = o_valid; s_data = o_data; s_last = o_last;
    n_checks++;
    if (o_r_en && (i_empty || reset)) begin
      n_errors++;
      $display("FAIL ren_guard: o_r_en=%0b with i_empty=%0b reset=%0b", o_r_en, i_empty, reset);
    end
    if (prev_stall && !reset) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== prev_data || o_last !== prev_last) begin
        n_errors++;
        $display("FAIL stable: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                 o_valid, o_data, o_last, prev_data, prev_last);
      end
    end
    prev_stall = !reset && o_valid && !i_ready;
    prev_data  = o_data;
    prev_last  = o_last;
    if (o_valid) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
    if (o_valid && i_ready) begin
      delivered++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL word: got unexpected word %0h expected none", o_data);
      end else begin
        exp_w = exp_q.pop_front();
        exp_l = BURST_MODE ? (delivered % BURST == 0) : 1'b0;
        if (o_data !== exp_w || o_last !== exp_l) begin
          n_errors++;
          $display("FAIL word: got d=%0h l=%0b expected d=%0h l=%0b", o_data, o_last, exp_w, exp_l);
        end
      end
    end
    if (ren) begin
      ren_cnt++;
      reads++;
      if (first_ren < 0) first_ren = cyc;
      n_checks++;
      if (reads - delivered > 2) begin
        n_errors++;
        $display("FAIL occupancy: got %0d outstanding expected <=2", reads - delivered);
      end
    end
    @(posedge clk);
    #1;
    if (ren && fifo_q.size() > 0) i_r_data = fifo_q.pop_front();
    else                          i_r_data = W'($urandom);
    cyc++;
    @(negedge clk);
  endtask

  task automatic start();
    reset = 1'b1;
    cycle();
    cycle();
    fifo_q.delete();
    exp_q.delete();
    reads = 0; delivered = 0; prev_stall = 1'b0; level = 4;
    reset = 1'b0;
    clear_stats();
  endtask

  // Run until all issued reads are delivered and no further read can start.
  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (!(reads == delivered &&
             (fifo_q.size() == 0 ||
              (BURST_MODE && reads % BURST == 0 && fifo_q.size() <= level))) &&
           k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d outstanding after %0d cycles expected 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_ready = 1'b1;
    push(8'hA5); push(8'h5A);
    cycle();
    n_checks++;
    if (s_ren !== 1'b0 || s_vld !== 1'b0 || s_data !== '0 || s_last !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: got ren=%0b v=%0b d=%0h l=%0b expected all 0", s_ren, s_vld, s_data, s_last);
    end
    fifo_q.delete(); exp_q.delete();
    reads = 0; delivered = 0; prev_stall = 1'b0;
    reset = 1'b0;
    cycle();
    n_checks++;
    if (s_ren !== 1'b0 || s_vld !== 1'b0 || s_data !== '0 || s_last !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got ren=%0b v=%0b d=%0h l=%0b expected all 0", s_ren, s_vld, s_data, s_last);
    end
  endtask

`ifndef FIFO_RD_BURST_EN
  task automatic test_stream();
    start();
    i_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(W'(i));
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (ren_cnt != 5 || vld_cnt != 5) begin
      n_errors++;
      $display("FAIL stream_counts: got ren=%0d valid=%0d expected 5 5", ren_cnt, vld_cnt);
    end
    n_checks++;
    if (first_vld - first_ren != 2 || last_vld - first_vld != 4) begin
      n_errors++;
      $display("FAIL stream_latency: got lat=%0d span=%0d expected 2 4",
               first_vld - first_ren, last_vld - first_vld);
    end
    n_checks++;
    if (delivered != 5 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stream_delivered: got %0d expected 5", delivered);
    end
  endtask
`endif

  task automatic test_backpressure();
    int exp_n;
    start();
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(W'(8'h10 + i));
    for (int i = 0; i < 4; i++) cycle();
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (i > 0) begin
        n_checks++;
        if (s_ren !== 1'b0) begin
          n_errors++;
          $display("FAIL bp_ren: got %0b expected 0 in stall cycle %0d", s_ren, i);
        end
      end
    end
    i_ready = 1'b1;
    drain("bp", 60);
    exp_n = BURST_MODE ? 8 : 10;
    n_checks++;
    if (delivered != exp_n) begin
      n_errors++;
      $display("FAIL bp_delivered: got %0d expected %0d", delivered, exp_n);
    end
  endtask

`ifdef FIFO_RD_BURST_EN
  task automatic test_burst_level();
    start();
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(W'(8'h30 + i));
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (ren_cnt != 0) begin
      n_errors++;
      $display("FAIL burst_below_level: got %0d reads expected 0", ren_cnt);
    end
    push(8'h33); push(8'h34);
    drain("burst", 40);
    for (int i = 0; i < 5; i++) cycle();
    n_checks++;
    if (ren_cnt != 4 || delivered != 4 || fifo_q.size() != 1) begin
      n_errors++;
      $display("FAIL burst_count: got reads=%0d delivered=%0d left=%0d expected 4 4 1",
               ren_cnt, delivered, fifo_q.size());
    end
  endtask

  task automatic test_burst_refill();
    start();
    level = 1;
    i_ready = 1'b1;
    push(8'h41); push(8'h42);
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (reads != 2) begin
      n_errors++;
      $display("FAIL refill_first: got %0d reads expected 2", reads);
    end
    for (int i = 0; i < 5; i++) cycle();
    n_checks++;
    if (reads != 2 || delivered != 2) begin
      n_errors++;
      $display("FAIL refill_pause: got reads=%0d delivered=%0d expected 2 2", reads, delivered);
    end
    push(8'h43); push(8'h44);
    drain("refill", 40);
    n_checks++;
    if (reads != 4 || delivered != 4) begin
      n_errors++;
      $display("FAIL refill_total: got reads=%0d delivered=%0d expected 4 4", reads, delivered);
    end
    level = 4;
  endtask
`endif

  task automatic test_reset_inflight();
    int k;
    start();
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(W'(8'h60 + i));
    k = 0;
    s_ren = 1'b0;
    while (!s_ren && k < 20) begin
      cycle();
      k++;
    end
    n_checks++;
    if (!s_ren) begin
      n_errors++;
      $display("FAIL rst_wait: got no read in 20 cycles expected one");
    end
    reset = 1'b1;
    cycle();
    n_checks++;
    if (s_ren !== 1'b0 || s_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_during: got ren=%0b v=%0b expected 0 0", s_ren, s_vld);
    end
    reset = 1'b0;
    exp_q = fifo_q;
    reads = 0; delivered = 0; prev_stall = 1'b0;
    cycle();
    n_checks++;
    if (s_vld !== 1'b0 || s_data !== '0 || s_last !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_after: got v=%0b d=%0h l=%0b expected 0 0 0", s_vld, s_data, s_last);
    end
    drain("rst", 60);
  endtask

  task automatic test_random();
    start();
    for (int i = 0; i < 400; i++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 20) push(W'($urandom));
      cycle();
    end
    i_ready = 1'b1;
    drain("random", 200);
    n_checks++;
    if (exp_q.size() != fifo_q.size()) begin
      n_errors++;
      $display("FAIL random_left: got %0d pending expected %0d", exp_q.size(), fifo_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; i_empty = 1'b1; i_aempty = 1'b1; i_ready = 1'b0; i_r_data = '0;
    n_checks = 0; n_errors = 0; cyc = 0; level = 4;
    reads = 0; delivered = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    clear_stats();
    @(negedge clk);
    test_reset();
`ifndef FIFO_RD_BURST_EN
    test_stream();
`endif
    test_backpressure();
`ifdef FIFO_RD_BURST_EN
    test_burst_level();
    test_burst_refill();
`endif
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WORD_WIDTH, default 8; width of read data and output data.
REQ-002 Parameter BURST, default 16; words per burst, legal range 2..256, used only when FIFO_RD_BURST_EN is defined.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_empty  input  1  FIFO empty flag, registered at the FIFO and valid in the current cycle.
REQ-006 i_aempty  input  1  FIFO almost-empty flag, high when FIFO count is at or below its LEVEL.
REQ-007 o_r_en  output  1  FIFO read enable.
REQ-008 i_r_data  input  WORD_WIDTH  FIFO read data, valid exactly one cycle after o_r_en was high with i_empty low.
REQ-009 o_valid  output  1  output word valid.
REQ-010 i_ready  input  1  downstream ready; a transfer occurs when o_valid and i_ready are both high.
REQ-011 o_data  output  WORD_WIDTH  output word.
REQ-012 o_last  output  1  marks the final word of a burst; qualified by o_valid.

Function
REQ-013 The block SHALL hold a 2-entry in-order output buffer of {data, last} plus one in-flight flag for the read issued in the previous cycle.
REQ-014 o_valid SHALL be high iff the buffer holds at least one entry; o_data and o_last SHALL come from the head entry.
REQ-015 pop SHALL be defined as o_valid && i_ready; o_r_en SHALL be combinational = read_allowed && !i_empty && (held + inflight - pop < 2).
REQ-016 o_r_en SHALL never be high while i_empty is high or reset is high.
REQ-017 The word on i_r_data SHALL be captured one cycle after each accepted read and appended to the buffer tail, tagged with the last bit computed at issue.
REQ-018 A simultaneous capture and pop SHALL leave the occupancy unchanged and preserve order; capture with a full buffer SHALL be impossible by REQ-015.
REQ-019 With i_ready held high and the FIFO non-empty, the block SHALL sustain one word per cycle after a 2-cycle startup latency from the first o_r_en to the first o_valid.
REQ-020 o_valid, o_data and o_last SHALL remain stable while o_valid && !i_ready.
REQ-021 Read data SHALL pass through unmodified; the block SHALL perform no width conversion.

Reset
REQ-022 While reset is high: o_r_en=0, o_valid=0, o_data=0, o_last=0, buffer cleared, in-flight flag cleared, state=IDLE, burst counter=0.
REQ-023 Reset asserted mid-burst or with a read in flight SHALL discard that data; the first cycle after reset SHALL behave like power-up.

Configuration
REQ-024 Macro FIFO_RD_BURST_EN SHALL select the burst-framing feature.
REQ-025 When FIFO_RD_BURST_EN is undefined, read_allowed SHALL be 1, o_last SHALL be tied 0, and no state machine or counter SHALL exist.
REQ-026 When FIFO_RD_BURST_EN is defined, the FSM SHALL have states IDLE and BURST.
REQ-027 IDLE->BURST SHALL occur when i_aempty=0, and read_allowed SHALL be 0 in IDLE.
REQ-028 In BURST, read_allowed SHALL be 1 and the counter SHALL increment on each issued read.
REQ-029 The read issued with counter==BURST-1 SHALL be tagged last, reset the counter to 0, and return the FSM to IDLE.
REQ-030 i_empty going high mid-burst SHALL stall issue without leaving BURST; the burst resumes when data returns.
REQ-031 Downstream backpressure SHALL stall issue per REQ-015 without affecting the counter.

Verification
REQ-032 Stream mode, WORD_WIDTH=8, FIFO preloaded 0x01..0x05, i_ready=1 -> o_r_en high 5 cycles, o_valid high 5 consecutive cycles carrying 0x01..0x05, o_last=0.
REQ-033 Stream mode, i_ready low for 3 cycles mid-stream -> o_r_en stops after the buffer holds 2 words, no word lost or duplicated, output sequence intact.
REQ-034 Burst mode, BURST=4, FIFO LEVEL=4, FIFO count 3 -> o_r_en stays 0. Writing 2 more (count 5) -> exactly 4 reads issued, o_last=1 only on the 4th word, FSM returns to IDLE.
REQ-035 Burst mode, FIFO empties after 2 of 4 words, refilled 5 cycles later -> reads pause, then resume, and o_last is asserted on the 4th word overall.
REQ-036 Reset asserted 1 cycle after an o_r_en -> next cycle o_valid=0, o_data=0, buffer empty, and no stale word ever appears on the output.
